// File: rtl/class_hvec_search_if.sv
// rtl/class_hvec_search_if.sv - query, class-generator and result signals of the class search
interface class_hvec_search_if #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int DIST_W             = 8
);
    logic                          start;
    logic [DI_PARALLEL_W_BITS-1:0] query_frame_in;
    logic                          query_valid;
    logic                          query_ready;
    logic [2:0]                    class_frame_id;
    logic [1:0]                    class_frame_index;
    logic [DI_PARALLEL_W_BITS-1:0] class_vec_in;
    logic [2:0]                    result_class;
    logic [DIST_W-1:0]             result_dist;
    logic                          result_valid;
    logic                          result_ready;
    logic                          busy;

    modport slave (
        input  start, query_frame_in, query_valid, class_vec_in, result_ready,
        output query_ready, class_frame_id, class_frame_index,
               result_class, result_dist, result_valid, busy
    );

    modport master (
        output start, query_frame_in, query_valid, class_vec_in, result_ready,
        input  query_ready, class_frame_id, class_frame_index,
               result_class, result_dist, result_valid, busy
    );
endinterface

// File: rtl/class_hvec_search.sv
// rtl/class_hvec_search.sv - nearest-class Hamming search over frame-serial hypervectors
module class_hvec_search #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int NUM_CLASSES        = 8,
    parameter int NUM_FRAMES         = 3,
    parameter int DIST_W             = 8
) (
    input  logic                clk,
    input  logic                rst,
    class_hvec_search_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMPARE, S_REDUCE, S_DONE
    } state_e;

    state_e                        state_q, state_d;
    logic [2:0]                    k_q, k_d;
    logic [1:0]                    f_q, f_d;
    logic [DI_PARALLEL_W_BITS-1:0] query_reg_q, query_reg_d;
    logic [DIST_W-1:0]             acc_q [NUM_CLASSES];
    logic [DIST_W-1:0]             acc_d [NUM_CLASSES];
    logic [2:0]                    result_class_q, result_class_d;
    logic [DIST_W-1:0]             result_dist_q, result_dist_d;

    logic [DI_PARALLEL_W_BITS-1:0] diff;
    logic [6:0]                    frame_pop;
    logic [2:0]                    min_idx;
    logic [DIST_W-1:0]             min_val;

    assign diff = query_reg_q ^ bus.class_vec_in;

    always_comb begin
        frame_pop = '0;
        for (int i = 0; i < DI_PARALLEL_W_BITS; i++) begin
            frame_pop = frame_pop + {6'd0, diff[i]};
        end
    end

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        min_idx = '0;
        min_val = acc_q[0];
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (acc_q[i] < min_val) begin
                min_val = acc_q[i];
                min_idx = 3'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        f_d            = f_q;
        query_reg_d    = query_reg_q;
        acc_d          = acc_q;
        result_class_d = result_class_q;
        result_dist_d  = result_dist_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < NUM_CLASSES; i++) acc_d[i] = '0;
                    f_d     = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.query_valid) begin
                    query_reg_d = bus.query_frame_in;
                    k_d         = '0;
                    state_d     = S_COMPARE;
                end
            end
            S_COMPARE: begin
                acc_d[k_q] = acc_q[k_q] + DIST_W'(frame_pop);
                if (k_q == 3'(NUM_CLASSES - 1)) begin
                    if (f_q == 2'(NUM_FRAMES - 1)) begin
                        state_d = S_REDUCE;
                    end else begin
                        f_d     = f_q + 2'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_REDUCE: begin
                result_class_d = min_idx;
                result_dist_d  = min_val;
                state_d        = S_DONE;
            end
            S_DONE: begin
                if (bus.result_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            k_q            <= '0;
            f_q            <= '0;
            query_reg_q    <= '0;
            result_class_q <= '0;
            result_dist_q  <= '0;
            for (int i = 0; i < NUM_CLASSES; i++) acc_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            f_q            <= f_d;
            query_reg_q    <= query_reg_d;
            result_class_q <= result_class_d;
            result_dist_q  <= result_dist_d;
            acc_q          <= acc_d;
        end
    end

    assign bus.query_ready       = (state_q == S_LOAD);
    assign bus.busy              = (state_q != S_IDLE);
    assign bus.result_valid      = (state_q == S_DONE);
    assign bus.result_class      = result_class_q;
    assign bus.result_dist       = result_dist_q;
    assign bus.class_frame_id    = (state_q == S_COMPARE) ? k_q : 3'd0;
    assign bus.class_frame_index = (state_q == S_COMPARE) ? f_q : 2'd0;
endmodule

// File: tb/tb_class_hvec_search.sv
// tb/tb_class_hvec_search.sv - randomized bench for class_hvec_search against a distance model
module tb_class_hvec_search;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    class_hvec_search_if #(.DI_PARALLEL_W_BITS(64), .DIST_W(8)) ifc ();

    class_hvec_search #(
        .DI_PARALLEL_W_BITS(64), .NUM_CLASSES(8), .NUM_FRAMES(3), .DIST_W(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    logic [63:0] cls [8][3];
    logic [63:0] q   [3];
    int          model_dist [8];
    int          model_class;
    int          model_min;
    int          errors = 0;
    int          checks = 0;

    always_comb begin
        if (ifc.class_frame_index < 2'd3)
            ifc.class_vec_in = cls[ifc.class_frame_id][ifc.class_frame_index];
        else
            ifc.class_vec_in = '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_run();
        model_class = 0;
        model_min   = 1 << 20;
        for (int c = 0; c < 8; c++) begin
            model_dist[c] = 0;
            for (int f = 0; f < 3; f++) model_dist[c] += $countones(q[f] ^ cls[c][f]);
            if (model_dist[c] < model_min) begin
                model_min   = model_dist[c];
                model_class = c;
            end
        end
    endfunction

    task automatic randomize_classes();
        for (int c = 0; c < 8; c++)
            for (int f = 0; f < 3; f++) cls[c][f] = {$urandom, $urandom};
    endtask

    task automatic run_query(input int stall, input int hold, input bit abort,
                             output logic [2:0] rc, output logic [7:0] rd, output int lat);
        int  n = 0;
        int  fi = 0;
        int  stalled = 0;
        bit  accepted;
        bit  done = 0;
        rc  = '0;
        rd  = '0;
        lat = -1;
        ifc.start        = 1'b1;
        ifc.result_ready = (hold == 0);
        while (n < 300 && !done) begin
            if (abort && ifc.class_frame_index == 2'd1 && ifc.class_frame_id == 3'd4) begin
                rst = 1'b1;
                ifc.start = 1'b1;
                ifc.query_valid = 1'b1;
                ifc.result_ready = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                ifc.start = 1'b0;
                ifc.query_valid = 1'b0;
                check("abort_busy", ifc.busy, 0);
                check("abort_qready", ifc.query_ready, 0);
                check("abort_rvalid", ifc.result_valid, 0);
                check("abort_rclass", ifc.result_class, 0);
                check("abort_rdist", ifc.result_dist, 0);
                check("abort_id", ifc.class_frame_id, 0);
                check("abort_idx", ifc.class_frame_index, 0);
                check("abort_acc3", dut.acc_q[3], 0);
                return;
            end
            ifc.query_frame_in = (fi < 3) ? q[fi] : '0;
            ifc.query_valid    = !(fi == 1 && ifc.query_ready && stalled < stall);
            accepted = ifc.query_ready && ifc.query_valid;
            if (fi == 1 && ifc.query_ready && !ifc.query_valid) stalled++;
            @(posedge clk); #1;
            n++;
            ifc.start = 1'b0;
            if (accepted) fi++;
            if (fi == 1 && stalled > 0 && stalled < stall) check("stall_qready", ifc.query_ready, 1);
            if (ifc.result_valid) done = 1;
        end
        if (!done) begin
            check("timeout", 0, 1);
            return;
        end
        lat = n;
        rc  = ifc.result_class;
        rd  = ifc.result_dist;
        check("done_id", ifc.class_frame_id, 0);
        check("done_idx", ifc.class_frame_index, 0);
        for (int h = 0; h < hold; h++) begin
            ifc.start = (h == 3);
            @(posedge clk); #1;
            check("hold_valid", ifc.result_valid, 1);
            check("hold_class", ifc.result_class, rc);
            check("hold_dist", ifc.result_dist, rd);
        end
        ifc.start = 1'b0;
        ifc.result_ready = 1'b1;
        @(posedge clk); #1;
        check("drop_valid", ifc.result_valid, 0);
        check("drop_busy", ifc.busy, 0);
    endtask

    logic [2:0] rc, rc0;
    logic [7:0] rd, rd0;
    int         lat;

    initial begin
        ifc.start = 0;
        ifc.query_valid = 0;
        ifc.query_frame_in = '0;
        ifc.result_ready = 0;
        randomize_classes();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_qready", ifc.query_ready, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_rvalid", ifc.result_valid, 0);
        check("rst_rclass", ifc.result_class, 0);
        check("rst_rdist", ifc.result_dist, 0);
        check("rst_id", ifc.class_frame_id, 0);
        check("rst_idx", ifc.class_frame_index, 0);

        // Query identical to class 3.
        for (int f = 0; f < 3; f++) q[f] = cls[3][f];
        run_query(0, 0, 0, rc, rd, lat);
        check("exact_class", rc, 3);
        check("exact_dist", rd, 0);
        check("exact_lat", lat, 29);

        // Query is the complement of class 5.
        for (int f = 0; f < 3; f++) q[f] = ~cls[5][f];
        model_run();
        run_query(0, 0, 0, rc, rd, lat);
        check("not5_class", rc, model_class);
        check("not5_dist", rd, model_min);
        check("not5_acc5", dut.acc_q[5], 192);

        // Classes 2 and 6 identical and nearest.
        randomize_classes();
        for (int f = 0; f < 3; f++) cls[6][f] = cls[2][f];
        for (int f = 0; f < 3; f++) q[f] = cls[2][f];
        q[0] = q[0] ^ 64'h0000_0F00_0000_0031;
        model_run();
        run_query(0, 0, 0, rc, rd, lat);
        check("tie_class", rc, 2);
        check("tie_dist", rd, model_min);

        // Stalled frame 1 against the same query without a stall.
        randomize_classes();
        for (int f = 0; f < 3; f++) q[f] = {$urandom, $urandom};
        model_run();
        run_query(0, 0, 0, rc0, rd0, lat);
        check("nostall_class", rc0, model_class);
        check("nostall_dist", rd0, model_min);
        run_query(5, 0, 0, rc, rd, lat);
        check("stall_class", rc, rc0);
        check("stall_dist", rd, rd0);
        check("stall_lat", lat, 34);

        // Held result in DONE with a stray start.
        run_query(0, 10, 0, rc, rd, lat);
        check("hold_res_class", rc, model_class);
        check("hold_res_dist", rd, model_min);

        // Reset in the middle of frame 1, then a fresh query.
        run_query(0, 0, 1, rc, rd, lat);
        randomize_classes();
        for (int f = 0; f < 3; f++) q[f] = cls[1][f] ^ {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        model_run();
        run_query(0, 0, 0, rc, rd, lat);
        check("post_rst_class", rc, model_class);
        check("post_rst_dist", rd, model_min);
        check("post_rst_lat", lat, 29);

        // Random queries, some biased toward a random class.
        for (int it = 0; it < 6; it++) begin
            int tgt;
            randomize_classes();
            tgt = $urandom_range(0, 7);
            for (int f = 0; f < 3; f++)
                q[f] = (it % 2 == 0) ? cls[tgt][f] ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom})
                                     : {$urandom, $urandom};
            model_run();
            run_query(0, 0, 0, rc, rd, lat);
            check("rand_class", rc, model_class);
            check("rand_dist", rd, model_min);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
